// File: rtl/alu_reservation_station_pkg.sv
// Shared opcode codes, ROB tag width, default station depth and index-width helper for the ALU reservation station.
// Imported by the station top; the bench uses the same opcode names.
package alu_reservation_station_pkg;

   localparam int ROBENTRY    = 4;
   localparam int RS_SIZE_DEF = 16;

   localparam logic [5:0] OP_LUI   = 6'd1;
   localparam logic [5:0] OP_AUIPC = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_JALR  = 6'd4;
   localparam logic [5:0] OP_BEQ   = 6'd5;
   localparam logic [5:0] OP_BNE   = 6'd6;
   localparam logic [5:0] OP_BLT   = 6'd7;
   localparam logic [5:0] OP_BGE   = 6'd8;
   localparam logic [5:0] OP_ADDI  = 6'd16;
   localparam logic [5:0] OP_ADD   = 6'd32;
   localparam logic [5:0] OP_SUB   = 6'd33;
   localparam logic [5:0] OP_AND   = 6'd34;
   localparam logic [5:0] OP_OR    = 6'd35;
   localparam logic [5:0] OP_XOR   = 6'd36;

   function automatic int rs_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag; purely combinational, no backpressure.
// Used by the reservation station for both free-slot search and ready-slot select.
module rs_prio_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until operands arrive via ALU/LSB CDB, issues one per cycle.
// Latency: dispatch-to-issue 2 cycles; RS_CDB_BYPASS_EN lets a CDB-completed entry issue in the broadcast cycle.
// Backpressure: rs_full blocks dispatch (a dispatch while full is dropped); rdy low freezes everything.
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF,
   parameter int ROB_W   = ROBENTRY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   input  logic             dsp_valid,
   input  logic [5:0]       dsp_opcode,
   input  logic             dsp_qj_busy,
   input  logic             dsp_qk_busy,
   input  logic [ROB_W-1:0] dsp_qj,
   input  logic [ROB_W-1:0] dsp_qk,
   input  logic [31:0]      dsp_vj,
   input  logic [31:0]      dsp_vk,
   input  logic [31:0]      dsp_imm,
   input  logic [31:0]      dsp_pc,
   input  logic [ROB_W-1:0] dsp_rob,
   output logic             rs_full,
   input  logic             alu_cdb_valid,
   input  logic [ROB_W-1:0] alu_cdb_rob,
   input  logic [31:0]      alu_cdb_value,
   input  logic             lsb_cdb_valid,
   input  logic [ROB_W-1:0] lsb_cdb_rob,
   input  logic [31:0]      lsb_cdb_value,
   output logic             RS_sgn,
   output logic [5:0]       RS_opcode,
   output logic [31:0]      lhs,
   output logic [31:0]      rhs,
   output logic [31:0]      imm,
   output logic [31:0]      pc,
   output logic [ROB_W-1:0] ROB_entry
);

   localparam int IW = rs_idx_w(RS_SIZE);

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
   logic [5:0]         op_q  [RS_SIZE];
   logic [5:0]         op_d  [RS_SIZE];
   logic [31:0]        vj_q  [RS_SIZE];
   logic [31:0]        vj_d  [RS_SIZE];
   logic [31:0]        vk_q  [RS_SIZE];
   logic [31:0]        vk_d  [RS_SIZE];
   logic [31:0]        imm_q [RS_SIZE];
   logic [31:0]        imm_d [RS_SIZE];
   logic [31:0]        pc_q  [RS_SIZE];
   logic [31:0]        pc_d  [RS_SIZE];
   logic [ROB_W-1:0]   qj_q  [RS_SIZE];
   logic [ROB_W-1:0]   qj_d  [RS_SIZE];
   logic [ROB_W-1:0]   qk_q  [RS_SIZE];
   logic [ROB_W-1:0]   qk_d  [RS_SIZE];
   logic [ROB_W-1:0]   rob_q [RS_SIZE];
   logic [ROB_W-1:0]   rob_d [RS_SIZE];

   logic             sgn_q, sgn_d;
   logic [5:0]       oop_q, oop_d;
   logic [31:0]      lhs_q, lhs_d, rhs_q, rhs_d, oimm_q, oimm_d, opc_q, opc_d;
   logic [ROB_W-1:0] orob_q, orob_d;

   logic [RS_SIZE-1:0] qj_pend, qk_pend, ready_vec;
   logic [31:0]        vj_snp [RS_SIZE];
   logic [31:0]        vk_snp [RS_SIZE];
   logic               dj_pend, dk_pend;
   logic [31:0]        dj_val, dk_val;
   logic [IW-1:0]      free_idx, sel_idx;
   logic               free_found, sel_found;

   // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
   function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                         input logic [31:0] cur);
      snoop = {pend, cur};
      if (pend && alu_cdb_valid && alu_cdb_rob == tag)
         snoop = {1'b0, alu_cdb_value};
      else if (pend && lsb_cdb_valid && lsb_cdb_rob == tag)
         snoop = {1'b0, lsb_cdb_value};
   endfunction

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         {qj_pend[i], vj_snp[i]} = snoop(qj_busy_q[i], qj_q[i], vj_q[i]);
         {qk_pend[i], vk_snp[i]} = snoop(qk_busy_q[i], qk_q[i], vk_q[i]);
      end
      {dj_pend, dj_val} = snoop(dsp_qj_busy, dsp_qj, dsp_vj);
      {dk_pend, dk_val} = snoop(dsp_qk_busy, dsp_qk, dsp_vk);
   end

`ifdef RS_CDB_BYPASS_EN
   assign ready_vec = busy_q & ~qj_pend & ~qk_pend;
`else
   assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;
`endif

   rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_free_enc (
      .req   (~busy_q),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_sel_enc (
      .req   (ready_vec),
      .idx   (sel_idx),
      .found (sel_found)
   );

   assign rs_full = ~free_found;

   always_comb begin
      busy_d    = busy_q;
      qj_busy_d = qj_pend;
      qk_busy_d = qk_pend;
      vj_d      = vj_snp;
      vk_d      = vk_snp;
      op_d      = op_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      qj_d      = qj_q;
      qk_d      = qk_q;
      rob_d     = rob_q;
      sgn_d     = 1'b0;
      oop_d     = oop_q;
      lhs_d     = lhs_q;
      rhs_d     = rhs_q;
      oimm_d    = oimm_q;
      opc_d     = opc_q;
      orob_d    = orob_q;
      if (clear) begin
         busy_d = '0;
      end else begin
         // Issue and dispatch never collide: one slot is busy, the other free.
         if (sel_found) begin
            busy_d[sel_idx] = 1'b0;
            sgn_d  = 1'b1;
            oop_d  = op_q[sel_idx];
            lhs_d  = vj_snp[sel_idx];
            rhs_d  = vk_snp[sel_idx];
            oimm_d = imm_q[sel_idx];
            opc_d  = pc_q[sel_idx];
            orob_d = rob_q[sel_idx];
         end
         if (dsp_valid && free_found) begin
            busy_d[free_idx]    = 1'b1;
            op_d[free_idx]      = dsp_opcode;
            qj_busy_d[free_idx] = dj_pend;
            qk_busy_d[free_idx] = dk_pend;
            vj_d[free_idx]      = dj_val;
            vk_d[free_idx]      = dk_val;
            qj_d[free_idx]      = dsp_qj;
            qk_d[free_idx]      = dsp_qk;
            imm_d[free_idx]     = dsp_imm;
            pc_d[free_idx]      = dsp_pc;
            rob_d[free_idx]     = dsp_rob;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q    <= '0;
         qj_busy_q <= '0;
         qk_busy_q <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]  <= '0;
            vj_q[i]  <= '0;
            vk_q[i]  <= '0;
            imm_q[i] <= '0;
            pc_q[i]  <= '0;
            qj_q[i]  <= '0;
            qk_q[i]  <= '0;
            rob_q[i] <= '0;
         end
         sgn_q  <= 1'b0;
         oop_q  <= '0;
         lhs_q  <= '0;
         rhs_q  <= '0;
         oimm_q <= '0;
         opc_q  <= '0;
         orob_q <= '0;
      end else if (rdy) begin
         busy_q    <= busy_d;
         qj_busy_q <= qj_busy_d;
         qk_busy_q <= qk_busy_d;
         op_q      <= op_d;
         vj_q      <= vj_d;
         vk_q      <= vk_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         qj_q      <= qj_d;
         qk_q      <= qk_d;
         rob_q     <= rob_d;
         sgn_q     <= sgn_d;
         oop_q     <= oop_d;
         lhs_q     <= lhs_d;
         rhs_q     <= rhs_d;
         oimm_q    <= oimm_d;
         opc_q     <= opc_d;
         orob_q    <= orob_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && rdy && !clear)
         assert (!(dsp_valid && rs_full))
            else $warning("alu_reservation_station: dispatch while full, op dropped");
   end

   assign RS_sgn    = sgn_q;
   assign RS_opcode = oop_q;
   assign lhs       = lhs_q;
   assign rhs       = rhs_q;
   assign imm       = oimm_q;
   assign pc        = opc_q;
   assign ROB_entry = orob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scenario bench for alu_reservation_station: expected issues are queued at dispatch and matched by a scoreboard.
// Latency expectations follow RS_CDB_BYPASS_EN when it is defined for the build.
module tb_alu_reservation_station;
   import alu_reservation_station_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        clear = 1'b0;
   logic        dsp_valid = 1'b0;
   logic [5:0]  dsp_opcode = '0;
   logic        dsp_qj_busy = 1'b0, dsp_qk_busy = 1'b0;
   logic [3:0]  dsp_qj = '0, dsp_qk = '0, dsp_rob = '0;
   logic [31:0] dsp_vj = '0, dsp_vk = '0, dsp_imm = '0, dsp_pc = '0;
   logic        rs_full;
   logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
   logic [3:0]  alu_cdb_rob = '0, lsb_cdb_rob = '0;
   logic [31:0] alu_cdb_value = '0, lsb_cdb_value = '0;
   logic        RS_sgn;
   logic [5:0]  RS_opcode;
   logic [31:0] lhs, rhs, imm, pc;
   logic [3:0]  ROB_entry;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] lhs;
      logic [31:0] rhs;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  rob;
   } exp_t;

   exp_t sb[$];
   exp_t sb_got, sb_exp;

   alu_reservation_station #(.RS_SIZE(16), .ROB_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .dsp_valid(dsp_valid), .dsp_opcode(dsp_opcode),
      .dsp_qj_busy(dsp_qj_busy), .dsp_qk_busy(dsp_qk_busy),
      .dsp_qj(dsp_qj), .dsp_qk(dsp_qk), .dsp_vj(dsp_vj), .dsp_vk(dsp_vk),
      .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob(dsp_rob), .rs_full(rs_full),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_value(alu_cdb_value),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_value(lsb_cdb_value),
      .RS_sgn(RS_sgn), .RS_opcode(RS_opcode), .lhs(lhs), .rhs(rhs), .imm(imm), .pc(pc),
      .ROB_entry(ROB_entry)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every issue cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && RS_sgn) begin
         sb_got = {RS_opcode, lhs, rhs, imm, pc, ROB_entry};
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected got %h required none", sb_got);
         end else begin
            sb_exp = sb.pop_front();
            if (sb_got !== sb_exp) begin
               n_fail++;
               $display("FAIL issue_fields got %h required %h", sb_got, sb_exp);
            end
         end
      end
   end

   function automatic exp_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] rob);
      return {op, a, b, 32'hA0 + {28'd0, rob}, 32'h1000 + {26'd0, rob, 2'b00}, rob};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dsp_valid     = 1'b0;
      alu_cdb_valid = 1'b0;
      lsb_cdb_valid = 1'b0;
      clear         = 1'b0;
   endtask

   task automatic drive_dsp(input logic [5:0] op, input logic jb, input logic [3:0] qj,
                            input logic [31:0] vj, input logic kb, input logic [3:0] qk,
                            input logic [31:0] vk, input logic [3:0] rob);
      dsp_valid   = 1'b1;
      dsp_opcode  = op;
      dsp_qj_busy = jb;
      dsp_qj      = qj;
      dsp_vj      = vj;
      dsp_qk_busy = kb;
      dsp_qk      = qk;
      dsp_vk      = vk;
      dsp_rob     = rob;
      dsp_imm     = 32'hA0 + {28'd0, rob};
      dsp_pc      = 32'h1000 + {26'd0, rob, 2'b00};
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_checks++;
      if ({RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b/%h/%h/%h/%h/%h/%h required all zero",
                  RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry);
      end
      n_checks++;
      if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b required 0", rs_full); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      drive_dsp(OP_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
      sb.push_back(mk(OP_ADD, 32'd5, 32'd7, 4'd3));
      step();
      idle();
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL single_early got %b required 0", RS_sgn); end
      step();
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL single_issue got %b required 1", RS_sgn); end
      step();
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b required 0", RS_sgn); end
   endtask

   task automatic test_wakeup();
      drive_dsp(OP_SUB, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1, 4'd5);
      sb.push_back(mk(OP_SUB, 32'h20, 32'd1, 4'd5));
      step();
      idle();
      step();
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL wake_wait got %b required 0", RS_sgn); end
      alu_cdb_valid = 1'b1;
      alu_cdb_rob   = 4'd9;
      alu_cdb_value = 32'h20;
      step();
      idle();
`ifdef RS_CDB_BYPASS_EN
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL wake_bypass got %b required 1", RS_sgn); end
`else
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL wake_latch got %b required 0", RS_sgn); end
      step();
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL wake_issue got %b required 1", RS_sgn); end
`endif
      step();
   endtask

   task automatic test_capture();
      alu_cdb_valid = 1'b1;
      alu_cdb_rob   = 4'd6;
      alu_cdb_value = 32'h55;
      drive_dsp(OP_AND, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'hF0, 4'd6);
      sb.push_back(mk(OP_AND, 32'h55, 32'hF0, 4'd6));
      step();
      idle();
      step();
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL capture_issue got %b required 1", RS_sgn); end
      step();
   endtask

   task automatic test_dual_cdb();
      int k;
      drive_dsp(OP_OR, 1'b0, 4'd0, 32'd3, 1'b1, 4'd4, 32'd0, 4'd4);
      sb.push_back(mk(OP_OR, 32'd3, 32'd1, 4'd4));
      step();
      idle();
      alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_value = 32'd1;
      lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd4; lsb_cdb_value = 32'd2;
      step();
      idle();
      k = 0;
      while (RS_sgn !== 1'b1 && k < 4) begin
         step();
         k++;
      end
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL dual_timeout got %b required 1", RS_sgn); end
      step();
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         drive_dsp(OP_ADD, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd100 + 32'(i), 4'(i));
         sb.push_back(mk(OP_ADD, 32'h100, 32'd100 + 32'(i), 4'(i)));
         step();
         if (i == 14) begin
            n_checks++;
            if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b required 0", rs_full); end
         end
      end
      n_checks++;
      if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set got %b required 1", rs_full); end
      drive_dsp(OP_XOR, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'hF);
      step();
      idle();
      n_checks++;
      if ({rs_full, RS_sgn} !== 2'b10) begin
         n_fail++;
         $display("FAIL full_drop got full=%b sgn=%b required full=1 sgn=0", rs_full, RS_sgn);
      end
      lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_value = 32'h100;
      step();
      idle();
`ifndef RS_CDB_BYPASS_EN
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL full_latch got %b required 0", RS_sgn); end
      step();
`endif
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL full_stream k=%0d got %b required 1", k, RS_sgn); end
         if (k == 0) begin
            n_checks++;
            if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_release got %b required 0", rs_full); end
         end
         step();
      end
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL full_tail got %b required 0", RS_sgn); end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 3; i++) begin
         drive_dsp(OP_ADD, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd1, 4'(i));
         step();
      end
      drive_dsp(OP_ADD, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd8);
      step();
      drive_dsp(OP_ADD, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd2, 4'd9);
      clear = 1'b1;
      step();
      idle();
      n_checks++;
      if ({RS_sgn, rs_full} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_state got sgn=%b full=%b required 0/0", RS_sgn, rs_full);
      end
      lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd7; lsb_cdb_value = 32'd0;
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL flush_empty k=%0d got %b required 0", k, RS_sgn); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive_dsp(OP_XOR, 1'b0, 4'd0, 32'h10 + 32'(i), 1'b0, 4'd0, 32'h3 * 32'(i), 4'd10 + 4'(i));
         sb.push_back(mk(OP_XOR, 32'h10 + 32'(i), 32'h3 * 32'(i), 4'd10 + 4'(i)));
         step();
         n_checks++;
         if (RS_sgn !== (i > 0)) begin n_fail++; $display("FAIL b2b_cycle i=%0d got %b required %b", i, RS_sgn, (i > 0)); end
      end
      idle();
      step();
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL b2b_last got %b required 1", RS_sgn); end
      step();
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b required 0", RS_sgn); end
   endtask

   task automatic test_stall();
      drive_dsp(OP_SUB, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd2, 4'd7);
      sb.push_back(mk(OP_SUB, 32'h77, 32'd2, 4'd7));
      step();
      idle();
      rdy = 1'b0;
      alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd11; alu_cdb_value = 32'h77;
      drive_dsp(OP_XOR, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd14);
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({RS_sgn, rs_full} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_hold k=%0d got sgn=%b full=%b required 0/0", k, RS_sgn, rs_full);
         end
      end
      rdy = 1'b1;
      dsp_valid = 1'b0;
      step();
      idle();
`ifndef RS_CDB_BYPASS_EN
      n_checks++;
      if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL stall_latch got %b required 0", RS_sgn); end
      step();
`endif
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL stall_resume got %b required 1", RS_sgn); end
      step();
   endtask

   task automatic test_async_reset();
      drive_dsp(OP_AND, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd9, 4'd12);
      sb.push_back(mk(OP_AND, 32'd9, 32'd9, 4'd12));
      step();
      drive_dsp(OP_ADD, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd4, 4'd13);
      step();
      idle();
      n_checks++;
      if (RS_sgn !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b required 1", RS_sgn); end
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry, rs_full} !== '0) begin
         n_fail++;
         $display("FAIL areset_now got sgn=%b op=%h lhs=%h rob=%h full=%b required all zero",
                  RS_sgn, RS_opcode, lhs, ROB_entry, rs_full);
      end
      #2;
      rst = 1'b1;
      step();
      lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd13; lsb_cdb_value = 32'h1;
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (RS_sgn !== 1'b0) begin n_fail++; $display("FAIL areset_gone k=%0d got %b required 0", k, RS_sgn); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wakeup();
      test_capture();
      test_dual_cdb();
      test_full();
      test_flush();
      test_back_to_back();
      test_stall();
      test_async_reset();
      step();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover got %0d pending required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Holds dispatched integer and branch/jump micro-ops until both source operands are available, then issues one per cycle to the combinational ALU. Sits between the decoder/dispatch stage and the ALU. Snoops the ALU and load/store CDBs to wake up waiting operands. Flushes on branch misprediction.

## Interface
- `RS_SIZE`, 16: number of entries; power of two, 2..32.
- `ROB_W`, 4: ROB tag width; equals the ROB entry width in `defines.v`.

- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all registers.
- `clear` in 1: misprediction flush.
- `dsp_valid` in 1: dispatch strobe.
- `dsp_opcode` in 6: opcode code from `defines.v`.
- `dsp_qj_busy` / `dsp_qk_busy` in 1: operand j/k still pending.
- `dsp_qj` / `dsp_qk` in ROB_W: producer tag when busy.
- `dsp_vj` / `dsp_vk` in 32: operand value when not busy.
- `dsp_imm`, `dsp_pc` in 32: immediate and instruction PC.
- `dsp_rob` in ROB_W: destination ROB tag.
- `rs_full` out 1: no free entry; combinational from the valid bits.
- `alu_cdb_valid`, `lsb_cdb_valid` in 1: broadcast strobes.
- `alu_cdb_rob`, `lsb_cdb_rob` in ROB_W: broadcast tags.
- `alu_cdb_value`, `lsb_cdb_value` in 32: broadcast values.
- `RS_sgn` out 1: issue valid to ALU; registered.
- `RS_opcode` out 6: registered.
- `lhs`, `rhs`, `imm`, `pc` out 32: registered.
- `ROB_entry` out ROB_W: registered.

## Operation
- **Entry fields:** `busy`, `opcode`, `vj`, `vk`, `qj_busy`, `qk_busy`, `qj`, `qk`, `imm`, `pc`, `rob`.
- **Dispatch:** when `dsp_valid` and not `rs_full`, write the lowest-index free entry.
  - `dsp_valid` while `rs_full`: the op is dropped. Simulation assertion fires.
- **Dispatch-time capture:** if a busy operand's tag matches a same-cycle CDB, store the CDB value and clear that busy bit.
- **Wake-up:** each busy entry compares `qj`/`qk` against both CDBs.
  - On match, latch the value and clear the busy bit.
  - If both CDBs carry the same tag, ALU wins.
- **Select:** the lowest-index entry with `busy` and both operands ready.
  - Selection uses registered state only; a just-dispatched entry is not eligible in its dispatch cycle.
- **Issue:** on the edge, the selected entry is copied to the output registers, `RS_sgn`=1, and the entry is freed. No candidate → `RS_sgn`=0 and other outputs hold.
- **Slot reuse:** issue and dispatch in the same cycle never target the same slot. Dispatch picks a free slot; issue frees a busy one.
- **Operand fields:** operands without a second source (I-type, LUI, AUIPC, JAL) are dispatched with `qk_busy`=0; `vk` is don't-care.
- **`clear`:** highest priority, synchronous. All `busy` cleared and `RS_sgn`=0 at the next edge; same-cycle dispatch and issue are discarded.
- **`rdy`=0:** all state and outputs hold, and CDB inputs are ignored. Producers are frozen by the same `rdy`.
- **Reset:** all entries not busy. `RS_sgn`, `RS_opcode`, `lhs`, `rhs`, `imm`, `pc`, `ROB_entry` = 0. `rs_full`=0.

## Timing
- Dispatch of a ready op at edge N → `RS_sgn`=1 after edge N+1, so minimum latency is 2 cycles.
- Last pending tag broadcast in cycle C:
  - value captured at edge C;
  - entry eligible in C+1;
  - `RS_sgn` after edge C+1 (without bypass).
- Issue throughput: 1 op/cycle.
- `rs_full` reflects a dispatch in the cycle after it.

## Configuration
- `RS_CDB_BYPASS_EN` defined: an entry whose only remaining pending operands are matched by a CDB in the current cycle is select-eligible in that cycle.
  - The CDB value is forwarded straight into `lhs`/`rhs`.
  - `RS_sgn` follows after edge C, saving one cycle.
  - ALU-over-LSB priority still applies.
- `RS_CDB_BYPASS_EN` undefined: selection considers only latched ready bits.

## Structure
- `defines.v` holds:
  - opcode codes;
  - `ROBENTRY` width;
  - the `RS_SIZE` default;
  - the entry index width `$clog2(RS_SIZE)`.
- Sub-module `rs_prio_enc`: a parameterised lowest-set-bit priority encoder with a found flag. It is instantiated twice, for free-slot search and ready-slot select.

## Test plan
- **Single ready op:** reset, then dispatch ADD `vj`=5, `vk`=7, rob=3 → `RS_sgn`=1 two cycles later with `lhs`=5, `rhs`=7, `ROB_entry`=3, `RS_opcode`=ADD; then 0 the next cycle.
- **Wake-up:** dispatch SUB with `qj_busy`, `qj`=9, `vk`=1, then `alu_cdb_valid`, rob=9, value=0x20 → issues with `lhs`=0x20, one cycle after the broadcast (zero extra with `RS_CDB_BYPASS_EN`).
- **Full and drop:** dispatch 16 ops all waiting on tag 2 → `rs_full`=1. A 17th dispatch is ignored and the assertion fires. LSB broadcasts tag 2 → 16 consecutive issues in index order; `rs_full` drops after the first issue.
- **Dual CDB:** both CDBs carry tag 4, ALU value 1 and LSB value 2 → the waiting operand latches 1.
- **Flush:** 3 entries busy and `clear` asserted with a concurrent dispatch → next cycle no entries busy, `RS_sgn`=0, `rs_full`=0.
- **Reset and stall:** async `rst` low mid-issue → outputs 0 immediately. `rdy` low for 3 cycles with a pending broadcast held → no state change; issue resumes after `rdy` returns.
